// File: rtl/mmio_rsp_merge_pkg.sv
// Shared types and constants for the MMIO read-response merge block.
package mmio_rsp_merge_pkg;

  localparam int MMIO_TID_W          = 9;
  localparam int MMIO_DATA_W         = 64;
  localparam int MMIO_RSP_COLL_CTR_W = 16;

  // One buffered MMIO read response.
  typedef struct packed {
    logic [MMIO_TID_W-1:0]  tid;
    logic [MMIO_DATA_W-1:0] data;
  } t_mmio_rsp;

  // Response source, also the encoding of the round-robin priority pointer.
  typedef enum logic {
    SRC_LOC = 1'b0,
    SRC_AFU = 1'b1
  } t_mmio_rsp_src;

endpackage

// File: rtl/mmio_rsp_fifo.sv
// Small synchronous FIFO of MMIO responses, one instance per source.
// A push to a full FIFO is accepted only when the same cycle pops it.
module mmio_rsp_fifo
  import mmio_rsp_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  t_mmio_rsp push_rsp,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output t_mmio_rsp head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  t_mmio_rsp       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  // NOTE: the array is not reset; clearing the pointers makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_rsp;
  end

endmodule

// File: rtl/mmio_rsp_merge.sv
// Merges the CSR manager's local MMIO read response (source 0) and the
// forwarded AFU-side response (source 1) onto one registered response
// channel. Each source has its own FIFO; a round-robin arbiter pops at most
// one response per cycle into the output register.
// Optional build macro: MMIO_RSP_MERGE_STATS_EN enables the collision counter.
module mmio_rsp_merge
  import mmio_rsp_merge_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TID_W  = MMIO_TID_W,
  parameter int DATA_W = MMIO_DATA_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           loc_rsp_valid,
  input  logic [TID_W-1:0]               loc_rsp_tid,
  input  logic [DATA_W-1:0]              loc_rsp_data,
  input  logic                           afu_rsp_valid,
  input  logic [TID_W-1:0]               afu_rsp_tid,
  input  logic [DATA_W-1:0]              afu_rsp_data,
  output logic                           out_rsp_valid,
  output logic [TID_W-1:0]               out_rsp_tid,
  output logic [DATA_W-1:0]              out_rsp_data,
  output logic                           ovf_err,
  output logic [MMIO_RSP_COLL_CTR_W-1:0] coll_count
);

  t_mmio_rsp     loc_in, afu_in;
  t_mmio_rsp     loc_head, afu_head;
  logic          loc_full, loc_empty, loc_pop;
  logic          afu_full, afu_empty, afu_pop;

  t_mmio_rsp_src prio_q, prio_d;
  logic          out_valid_q, out_valid_d;
  t_mmio_rsp     out_q, out_d;
  logic          ovf_q, ovf_d;

  assign loc_in.tid  = loc_rsp_tid;
  assign loc_in.data = loc_rsp_data;
  assign afu_in.tid  = afu_rsp_tid;
  assign afu_in.data = afu_rsp_data;

  mmio_rsp_fifo #(.DEPTH(DEPTH)) u_loc_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (loc_rsp_valid),
    .push_rsp (loc_in),
    .pop      (loc_pop),
    .full     (loc_full),
    .empty    (loc_empty),
    .head     (loc_head)
  );

  mmio_rsp_fifo #(.DEPTH(DEPTH)) u_afu_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (afu_rsp_valid),
    .push_rsp (afu_in),
    .pop      (afu_pop),
    .full     (afu_full),
    .empty    (afu_empty),
    .head     (afu_head)
  );

  // Round-robin grant, output register next value and overflow detection.
  always_comb begin
    loc_pop     = 1'b0;
    afu_pop     = 1'b0;
    prio_d      = prio_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    if (!loc_empty && (afu_empty || prio_q == SRC_LOC)) begin
      loc_pop     = 1'b1;
      out_valid_d = 1'b1;
      out_d       = loc_head;
      prio_d      = SRC_AFU;
    end else if (!afu_empty) begin
      afu_pop     = 1'b1;
      out_valid_d = 1'b1;
      out_d       = afu_head;
      prio_d      = SRC_LOC;
    end
    // A push to a full FIFO that is not popped this cycle is lost.
    ovf_d = ovf_q
          | (loc_rsp_valid && loc_full && !loc_pop)
          | (afu_rsp_valid && afu_full && !afu_pop);
  end

  // Priority pointer, output register and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q      <= SRC_LOC;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_rsp_valid = out_valid_q;
  assign out_rsp_tid   = out_q.tid;
  assign out_rsp_data  = out_q.data;
  assign ovf_err       = ovf_q;

`ifdef MMIO_RSP_MERGE_STATS_EN
  logic [MMIO_RSP_COLL_CTR_W-1:0] coll_q, coll_d;

  // Saturating count of cycles where both sources deliver a response.
  always_comb begin
    coll_d = coll_q;
    if (loc_rsp_valid && afu_rsp_valid && coll_q != '1)
      coll_d = coll_q + MMIO_RSP_COLL_CTR_W'(1);
  end

  // Collision counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coll_q <= '0;
    else          coll_q <= coll_d;
  end

  assign coll_count = coll_q;
`else
  assign coll_count = '0;
`endif

endmodule
